// File: rtl/fifod2mac_arb.sv
// fifod2mac_arb: round-robin arbiter that streams one of NCH FIFO sources to the UDP/MAC
// transmitter. A granted channel's data_len words are read, delayed by the FIFO read latency
// and forwarded on udp_txd, then fd is raised to that channel until it drops fs.
// Optional build macro: FIFOD2MAC_IFG_EN adds an idle GAP state of IFG_CYCLES after each frame.
module fifod2mac_arb #(
  parameter int NCH        = 4,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 12,
  parameter int RD_LAT     = 1,
  parameter int IFG_CYCLES = 12,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        fs,
  output logic [NCH-1:0]        fd,
  input  logic [NCH*LEN_W-1:0]  data_len,
  output logic [NCH-1:0]        fifod_rxen,
  input  logic [NCH*DATA_W-1:0] fifod_rxd,
  output logic                  udp_txen,
  output logic [DATA_W-1:0]     udp_txd,
  output logic [CH_W-1:0]       udp_tx_ch,
  input  logic                  flag_udp_tx_prep,
  output logic                  flag_udp_tx_req,
  output logic [3:0]            state_out
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StMacReq = 4'd1,
    StWork   = 4'd2,
    StDrain  = 4'd3,
`ifdef FIFOD2MAC_IFG_EN
    StLast   = 4'd4,
    StGap    = 4'd5
`else
    StLast   = 4'd4
`endif
  } state_t;

  localparam logic [NCH-1:0] One = 1;

  state_t            state_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   ptr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  rd_cnt_q;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic [RD_LAT:0]   vld_ext;
  logic              rxen_act;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   ptr_next;
  logic [LEN_W-1:0]  gnt_len;

`ifdef FIFOD2MAC_IFG_EN
  // IFG_CYCLES of zero still spends one cycle in GAP
  localparam int GapLen = (IFG_CYCLES == 0) ? 1 : IFG_CYCLES;
  logic [15:0] gap_q;
`endif

  // Round-robin search for the first requester starting at ptr_q
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_found && fs[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
    ptr_next = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + CH_W'(1);
    gnt_len  = data_len[gnt_idx*LEN_W +: LEN_W];
  end

  // Read-valid shift chain; its tail is the transmit strobe
  always_comb begin
    rxen_act = (state_q == StWork);
    vld_ext  = {vld_q, rxen_act};
    vld_d    = vld_ext[RD_LAT-1:0];
  end

  // Valid pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // Main FSM with latched channel, length and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
`ifdef FIFOD2MAC_IFG_EN
      gap_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            ch_q    <= gnt_idx;
            len_q   <= gnt_len;
            ptr_q   <= ptr_next;
            state_q <= (gnt_len == '0) ? StLast : StMacReq;
          end
        end
        StMacReq: begin
          rd_cnt_q <= '0;
          if (flag_udp_tx_prep) state_q <= StWork;
        end
        StWork: begin
          // LEN_W-wide compare keeps len = 2^LEN_W-1 legal
          if (rd_cnt_q == len_q - LEN_W'(1)) begin
            rd_cnt_q <= '0;
            state_q  <= StDrain;
          end else begin
            rd_cnt_q <= rd_cnt_q + LEN_W'(1);
          end
        end
        StDrain: begin
          if (vld_d == '0) state_q <= StLast;
        end
        StLast: begin
          if (!fs[ch_q]) begin
`ifdef FIFOD2MAC_IFG_EN
            gap_q   <= '0;
            state_q <= StGap;
`else
            state_q <= StIdle;
`endif
          end
        end
`ifdef FIFOD2MAC_IFG_EN
        StGap: begin
          if (gap_q == 16'(GapLen - 1)) state_q <= StIdle;
          else                          gap_q   <= gap_q + 16'd1;
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decoded from registered state; they drop with the async reset
  always_comb begin
    fifod_rxen      = rxen_act ? (One << ch_q) : '0;
    fd              = (state_q == StLast) ? (One << ch_q) : '0;
    flag_udp_tx_req = (state_q == StMacReq);
    udp_txen        = vld_q[RD_LAT-1];
    udp_txd         = udp_txen ? fifod_rxd[ch_q*DATA_W +: DATA_W] : '0;
    udp_tx_ch       = ch_q;
    state_out       = state_q;
  end

endmodule

// File: tb/tb_fifod2mac_arb.sv
// Bench for fifod2mac_arb: table of frames on a RD_LAT=1 instance, plus hand-written
// mid-frame reset and RD_LAT=3 drain sequences.
module tb_fifod2mac_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic [3:0]  fs_a = '0, fd_a, rxen_a;
  logic [47:0] len_a = '0;
  logic [31:0] rxd_a = '0;
  logic        txen_a, req_a;
  logic        prep_a = 1'b0;
  logic [7:0]  txd_a;
  logic [1:0]  ch_a;
  logic [3:0]  st_a;

  // Instance B: RD_LAT = 3
  logic [3:0]  fs_b = '0, fd_b, rxen_b;
  logic [47:0] len_b = '0;
  logic [31:0] rxd_b;
  logic        txen_b, req_b;
  logic        prep_b = 1'b0;
  logic [7:0]  txd_b;
  logic [1:0]  ch_b;
  logic [3:0]  st_b;

  fifod2mac_arb u_dut_a (
    .clk(clk), .rst_n(rst_n), .fs(fs_a), .fd(fd_a), .data_len(len_a),
    .fifod_rxen(rxen_a), .fifod_rxd(rxd_a), .udp_txen(txen_a), .udp_txd(txd_a),
    .udp_tx_ch(ch_a), .flag_udp_tx_prep(prep_a), .flag_udp_tx_req(req_a), .state_out(st_a)
  );

  fifod2mac_arb #(.RD_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .fs(fs_b), .fd(fd_b), .data_len(len_b),
    .fifod_rxen(rxen_b), .fifod_rxd(rxd_b), .udp_txen(txen_b), .udp_txd(txd_b),
    .udp_tx_ch(ch_b), .flag_udp_tx_prep(prep_b), .flag_udp_tx_req(req_b), .state_out(st_b)
  );

  // FIFO model A: one-cycle read latency, word = {channel, running count}
  logic [5:0] cnt_a [4] = '{default: 6'd0};
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rxen_a[c]) begin
        rxd_a[c*8 +: 8] <= {2'(c), cnt_a[c]};
        cnt_a[c]        <= cnt_a[c] + 6'd1;
      end
    end
  end

  // FIFO model B: three-cycle read latency on channel 0
  logic [7:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;
  always @(posedge clk) begin
    b_p1 <= rxen_b[0] ? 8'hA5 : 8'h00;
    b_p2 <= b_p1;
    b_p3 <= b_p2;
  end
  assign rxd_b = {24'h0, b_p3};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] fs;        // request mask applied for this frame
    int         len;       // data_len on every channel
    int         prep_dly;  // req cycles before prep is raised
    int         ch;        // expected granted channel
    int         first;     // expected cycle of first req (or fd when len==0)
  } vec_t;

  // Runs one frame on instance A; called at a negedge with the DUT in IDLE
  task automatic run_frame(input vec_t v);
    int cyc = 0, req_n = 0, rxen_n = 0, txen_n = 0, bad_d = 0, bad_rx = 0, first = -1, k = 0;
    bit done = 1'b0;
    logic [5:0] base;
    base   = cnt_a[v.ch];
    len_a  = {4{12'(v.len)}};
    fs_a   = v.fs;
    prep_a = 1'b0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (first < 0 && (req_a || fd_a != 4'h0)) first = cyc;
      if (req_a) begin
        req_n++;
        prep_a = (req_n >= v.prep_dly);
      end else begin
        prep_a = 1'b0;
      end
      if (rxen_a != 4'h0) begin
        rxen_n++;
        if (rxen_a != 4'(1 << v.ch)) bad_rx++;
      end
      if (txen_a) begin
        if (txd_a !== {2'(v.ch), 6'(base + 6'(k))}) bad_d++;
        k++;
        txen_n++;
      end
      if (fd_a != 4'h0) done = 1'b1;
    end
    check("fd_seen", 32'(done), 1);
    check("grant_ch", 32'(ch_a), 32'(v.ch));
    check("fd_onehot", 32'(fd_a), 32'(1 << v.ch));
    check("first_cycle", 32'(first), 32'(v.first));
    check("req_cycles", 32'(req_n), (v.len == 0) ? 0 : 32'(v.prep_dly));
    check("rxen_cycles", 32'(rxen_n), 32'(v.len));
    check("rxen_onehot_errs", 32'(bad_rx), 0);
    check("txen_cycles", 32'(txen_n), 32'(v.len));
    check("txd_errs", 32'(bad_d), 0);
    @(negedge clk);
    check("fd_held", 32'(fd_a), 32'(1 << v.ch));
    fs_a[v.ch] = 1'b0;
    @(negedge clk);
    check("fd_released", 32'(fd_a), 0);
    check("idle_after_fd", 32'(st_a), 0);
  endtask

  vec_t vecs [7];

  initial begin
    int cyc, rx_n, tx_n, rx_cyc, tx_cyc, drain_n, bad;
    bit done;
    vecs[0] = '{fs: 4'b1011, len: 3,    prep_dly: 1, ch: 0, first: 1};
    vecs[1] = '{fs: 4'b1011, len: 3,    prep_dly: 1, ch: 1, first: 1};
    vecs[2] = '{fs: 4'b1011, len: 3,    prep_dly: 1, ch: 3, first: 1};
    vecs[3] = '{fs: 4'b1011, len: 3,    prep_dly: 1, ch: 0, first: 1};
    vecs[4] = '{fs: 4'b0100, len: 5,    prep_dly: 3, ch: 2, first: 1};
    vecs[5] = '{fs: 4'b0010, len: 0,    prep_dly: 1, ch: 1, first: 1};
    vecs[6] = '{fs: 4'b0001, len: 4095, prep_dly: 2, ch: 0, first: 1};

    // Reset state
    #12;
    check("rst_state", 32'(st_a), 0);
    check("rst_fd", 32'(fd_a), 0);
    check("rst_rxen", 32'(rxen_a), 0);
    check("rst_txen", 32'(txen_a), 0);
    check("rst_req", 32'(req_a), 0);
    check("rst_ch", 32'(ch_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset during WORK with rd_cnt = 7 of 20, then a fresh full frame
    len_a  = {4{12'd20}};
    fs_a   = 4'b1000;
    prep_a = 1'b1;
    cyc    = 0;
    rx_n   = 0;
    while (rx_n < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rxen_a != 4'h0) rx_n++;
    end
    check("pre_reset_rxen_count", 32'(rx_n), 8);
    check("pre_reset_txen", 32'(txen_a), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rxen", 32'(rxen_a), 0);
    check("midrst_txen", 32'(txen_a), 0);
    check("midrst_req", 32'(req_a), 0);
    check("midrst_fd", 32'(fd_a), 0);
    check("midrst_state", 32'(st_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame('{fs: 4'b1000, len: 20, prep_dly: 1, ch: 3, first: 1});

    // RD_LAT = 3, len = 1: one read, strobe three cycles later, three DRAIN cycles
    len_b   = {4{12'd1}};
    fs_b    = 4'b0001;
    prep_b  = 1'b1;
    cyc     = 0;
    rx_n    = 0;
    tx_n    = 0;
    rx_cyc  = 0;
    tx_cyc  = 0;
    drain_n = 0;
    bad     = 0;
    done    = 1'b0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (rxen_b[0]) begin
        rx_n++;
        rx_cyc = cyc;
      end
      if (txen_b) begin
        tx_n++;
        tx_cyc = cyc;
        if (txd_b !== 8'hA5) bad++;
      end
      if (st_b == 4'd3) drain_n++;
      if (fd_b[0]) done = 1'b1;
    end
    check("lat3_fd_seen", 32'(done), 1);
    check("lat3_rxen_cycles", 32'(rx_n), 1);
    check("lat3_txen_cycles", 32'(tx_n), 1);
    check("lat3_txen_delay", 32'(tx_cyc - rx_cyc), 3);
    check("lat3_drain_cycles", 32'(drain_n), 3);
    check("lat3_txd_errs", 32'(bad), 0);
    fs_b = 4'b0000;
    @(negedge clk);
    check("lat3_idle", 32'(st_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
